ysyx_25030081_regfile_sb: RTL

YSYX_25030081_REGFILE_SB -- requirements
Module: ysyx_25030081_regfile_sb

---
 rtl/ysyx_25030081_regfile_sb.sv | 57 +++++
 1 files changed

// File: rtl/ysyx_25030081_regfile_sb.sv
// ysyx_25030081_regfile_sb: register file with per-register busy scoreboard, multi-port combinational reads.
// Optional macro YSYX_25030081_RF_BYPASS_EN forwards same-cycle write data to matching read ports.
module ysyx_25030081_regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wen,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [NR_READ*ADDR_WIDTH-1:0]    raddr,
    output logic [NR_READ*DATA_WIDTH-1:0]    rdata,
    output logic [NR_READ-1:0]               rbusy,
    input  logic                             iss_valid,
    input  logic [ADDR_WIDTH-1:0]            iss_rd,
    output logic                             iss_ready
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  wr_en;
    logic                  iss_en;

    assign wr_en     = wen && waddr != '0;
    assign iss_ready = rst || iss_rd == '0 || !busy[iss_rd];
    assign iss_en    = iss_valid && iss_ready && iss_rd != '0;

    // Issue set is applied after the write clear so a same-index collision leaves the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
            busy <= '0;
        end else begin
            if (wr_en) begin
                regs[waddr] <= wdata;
                busy[waddr] <= 1'b0;
            end
            if (iss_en) busy[iss_rd] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NR_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;
        assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef YSYX_25030081_RF_BYPASS_EN
        assign hit = wr_en && waddr == ra;
`else
        assign hit = 1'b0;
`endif
        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = (rst || ra == '0) ? '0 : hit ? wdata : regs[ra];
        assign rbusy[i] = !rst && !hit && ra != '0 && busy[ra];
    end
endmodule
